seg_scan_driver: RTL and testbench
==================================

// Module: seg_scan_driver
// PURPOSE
//   Time-multiplexed display driver: the consumer end of the stopwatch's six parallel
//   7-segment outputs. Drives them onto one shared segment bus plus six digit enables.
//   Snapshots all six patterns once per frame, so a digit never tears mid-frame.
//   Inserts a dead-time blank between digits and blinks selected digits at 2 Hz.
//   Sits between the stopwatch core and the board's common-anode display pins.
// PARAMETERS
//   CLK_HZ     50_000_000  input clock frequency
//   SCAN_HZ    1_000       digit-slot rate; DIV = CLK_HZ/SCAN_HZ cycles per slot
//   BLANK_CYC  50          dead-time cycles at start of each slot; elaboration error if >= DIV
//   BLINK_DIV  CLK_HZ/4    cycles per blink-phase toggle (2 Hz blink)
// PORTS
//   Clk        in   1   system clock
//   Rst        in   1   synchronous reset, active-high
//   i_Seg0..5  in   7   per-digit patterns, active-low (bit=0 lit), bit0=a..bit6=g; digit 0 = rightmost
//   i_Blink    in   6   per-digit blink enable, bit k -> digit k
//   o_Seg      out  7   shared segment bus, active-low
//   o_Dig      out  6   digit enables, active-low, at most one low at any time
//   o_Frame    out  1   one-cycle pulse when the frame snapshot is taken
// BEHAVIOUR
//   Reset (Clk edge with Rst=1): slot counter c=0, digit index idx=0, blink phase bp=0, state BLANK.
//     Also o_Seg=7'h7F, o_Dig=6'h3F, o_Frame=0, all snapshot regs=7'h7F. Rst mid-slot aborts immediately.
//   Slot counter: c counts 0..DIV-1 and wraps. On wrap, idx advances 0->1->...->5->0.
//   Snapshot: when idx wraps 5->0, and on the first cycle after reset, all six i_SegK are latched.
//     o_Frame pulses high for exactly that cycle. Input changes at any other time are ignored.
//   FSM:
//     BLANK (c < BLANK_CYC): o_Dig=6'h3F, o_Seg=7'h7F.
//     DRIVE (BLANK_CYC <= c <= DIV-1): o_Dig low only at bit idx; o_Seg = snap[idx].
//     BLANK->DRIVE when c reaches BLANK_CYC. DRIVE->BLANK on the c wrap, which also advances idx.
//   Blink:
//     Counter b counts 0..BLINK_DIV-1; bp toggles on its wrap.
//     In DRIVE with bp=1 and i_Blink[idx]=1: o_Dig still enabled, o_Seg forced to 7'h7F.
//     i_Blink is sampled live, not snapshotted.
//   All outputs are registered: one cycle of latency from the internal c/idx/bp state to the pins.
//   Boundaries:
//     Switching between digits always passes through >= BLANK_CYC cycles with all enables high,
//     so no two digits are ever enabled together.
//     When a snapshot and a blink toggle fall on the same cycle, both take effect.
//     BLANK_CYC=0 is legal: there is no BLANK state, and DRIVE lasts the whole slot.
//   Widths: c is $clog2(DIV) bits; b is $clog2(BLINK_DIV) bits; idx is 3 bits, never 6 or 7.
// TESTING  (bench params CLK_HZ=1000, SCAN_HZ=100 -> DIV=10, BLANK_CYC=2, BLINK_DIV=250)
//   1 Reset: hold Rst=1 for 3 clocks -> o_Seg=7'h7F, o_Dig=6'h3F, o_Frame=0.
//     Release -> o_Frame pulses once within 2 clocks.
//   2 Scan order: i_Seg0..5 = 7'h40,7'h79,7'h24,7'h30,7'h19,7'h12; i_Blink=0.
//     Required: the low bit of o_Dig walks 0..5, 8 clocks per digit, with 2 blank clocks between.
//     o_Seg matches each digit; the frame repeats every 60 clocks.
//   3 No tearing: change i_Seg3 to 7'h00 while digit 1 is driven.
//     Required: digit 3 still shows 7'h30 this frame, shows 7'h00 next frame, and o_Frame pulses at the boundary.
//   4 Blink: i_Blink=6'b000100.
//     Required: digit 2 shows 7'h24 for 250 clocks, then 7'h7F for 250 clocks with o_Dig[2] still low in DRIVE.
//     Other digits are unaffected.
//   5 Mid-slot reset: assert Rst at c=5 of digit 4 -> next clock o_Dig=6'h3F.
//     After release, scanning restarts at digit 0.
//   6 Overlap check: across 2000 clocks, assert o_Dig never has more than one low bit.
//     Also assert o_Dig=6'h3F whenever c < BLANK_CYC (delayed by one cycle).

Source files
------------

// File: rtl/seg_scan_driver.sv
// seg_scan_driver
//   Time-multiplexed driver for a six-digit common-anode 7-segment display.
//   All six digit patterns are snapshotted once per frame so a digit never
//   tears mid-frame. Each digit slot opens with a dead-time blank. Selected
//   digits blink at the BLINK_DIV toggle rate.
//
// Ports
//   Clk        in   1  system clock
//   Rst        in   1  synchronous reset, active-high
//   i_Seg0..5  in   7  per-digit patterns, active-low, bit0=a..bit6=g, digit 0 rightmost
//   i_Blink    in   6  per-digit blink enable (live, not snapshotted)
//   o_Seg      out  7  shared segment bus, active-low
//   o_Dig      out  6  digit enables, active-low, at most one low
//   o_Frame    out  1  one-cycle pulse marking the frame snapshot
module seg_scan_driver #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int SCAN_HZ   = 1_000,
    parameter int BLANK_CYC = 50,
    parameter int BLINK_DIV = CLK_HZ / 4
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [6:0] i_Seg0,
    input  logic [6:0] i_Seg1,
    input  logic [6:0] i_Seg2,
    input  logic [6:0] i_Seg3,
    input  logic [6:0] i_Seg4,
    input  logic [6:0] i_Seg5,
    input  logic [5:0] i_Blink,
    output logic [6:0] o_Seg,
    output logic [5:0] o_Dig,
    output logic       o_Frame
);
    localparam int DIV = CLK_HZ / SCAN_HZ;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] C_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] C_BLANK = CW'(BLANK_CYC);
    localparam logic [BW-1:0] B_LAST  = BW'(BLINK_DIV - 1);

    if (BLANK_CYC >= DIV) begin : g_blank_check
        $error("seg_scan_driver: BLANK_CYC must be smaller than CLK_HZ/SCAN_HZ");
    end

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } state_t;

    state_t          state_q;
    state_t          state_nxt;
    logic [CW-1:0]   c_q;
    logic [CW-1:0]   c_nxt;
    logic            c_wrap;
    logic [2:0]      idx_q;
    logic [2:0]      idx_nxt;
    logic [BW-1:0]   b_q;
    logic            bp_q;
    logic            first_q;
    logic            take;
    logic [6:0]      snap_q [6];
    logic [6:0]      seg_nxt;
    logic [5:0]      dig_nxt;

    // State register
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= BLANK;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state, slot bookkeeping and pin values for the next cycle
    always_comb begin
        c_wrap    = (c_q == C_LAST);
        c_nxt     = c_wrap ? '0 : c_q + 1'b1;
        idx_nxt   = idx_q;
        state_nxt = state_q;
        seg_nxt   = 7'h7F;
        dig_nxt   = 6'h3F;

        if (c_wrap) begin
            idx_nxt = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
        end

        case (state_q)
            // With BLANK_CYC=0 this leaves BLANK straight after reset.
            BLANK:   if (c_nxt >= C_BLANK) state_nxt = DRIVE;
            DRIVE:   if (c_wrap && (BLANK_CYC != 0)) state_nxt = BLANK;
            default: state_nxt = BLANK;
        endcase

        // First cycle out of reset and every 5->0 index wrap take a snapshot.
        take = first_q || (c_wrap && (idx_q == 3'd5));

        if (state_q == DRIVE) begin
            dig_nxt = ~(6'd1 << idx_q);
            // Blink keeps the digit enabled but blanks its segments.
            if (!(bp_q && i_Blink[idx_q])) begin
                seg_nxt = snap_q[idx_q];
            end
        end
    end

    // Counters, snapshot and registered pins
    always_ff @(posedge Clk) begin
        if (Rst) begin
            c_q     <= '0;
            idx_q   <= 3'd0;
            b_q     <= '0;
            bp_q    <= 1'b0;
            first_q <= 1'b1;
            o_Seg   <= 7'h7F;
            o_Dig   <= 6'h3F;
            o_Frame <= 1'b0;
            for (int k = 0; k < 6; k++) begin
                snap_q[k] <= 7'h7F;
            end
        end else begin
            c_q     <= c_nxt;
            idx_q   <= idx_nxt;
            first_q <= 1'b0;
            if (b_q == B_LAST) begin
                b_q  <= '0;
                bp_q <= ~bp_q;
            end else begin
                b_q <= b_q + 1'b1;
            end
            if (take) begin
                snap_q[0] <= i_Seg0;
                snap_q[1] <= i_Seg1;
                snap_q[2] <= i_Seg2;
                snap_q[3] <= i_Seg3;
                snap_q[4] <= i_Seg4;
                snap_q[5] <= i_Seg5;
            end
            o_Seg   <= seg_nxt;
            o_Dig   <= dig_nxt;
            o_Frame <= take;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
module tb_seg_scan_driver;
    localparam int CLK_HZ    = 1000;
    localparam int SCAN_HZ   = 100;
    localparam int BLANK_CYC = 2;
    localparam int BLINK_DIV = 250;
    localparam int DIV       = CLK_HZ / SCAN_HZ;
    localparam int FRAME     = 6 * DIV;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic [6:0] seg_in [6];
    logic [5:0] blink = 6'h00;
    logic [6:0] o_seg;
    logic [5:0] o_dig;
    logic       o_frame;

    int n_checks = 0;
    int n_fail   = 0;
    bit checking = 1'b0;

    seg_scan_driver #(
        .CLK_HZ   (CLK_HZ),
        .SCAN_HZ  (SCAN_HZ),
        .BLANK_CYC(BLANK_CYC),
        .BLINK_DIV(BLINK_DIV)
    ) dut (
        .Clk    (Clk),
        .Rst    (Rst),
        .i_Seg0 (seg_in[0]),
        .i_Seg1 (seg_in[1]),
        .i_Seg2 (seg_in[2]),
        .i_Seg3 (seg_in[3]),
        .i_Seg4 (seg_in[4]),
        .i_Seg5 (seg_in[5]),
        .i_Blink(blink),
        .o_Seg  (o_seg),
        .o_Dig  (o_dig),
        .o_Frame(o_frame)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: everything is derived from n, the number of
    // non-reset clock edges since reset was released.
    int         n;
    int         m_c;
    int         m_idx;
    int         m_bp;
    logic [6:0] snap_m [6];
    logic [6:0] exp_seg;
    logic [5:0] exp_dig;
    logic       exp_frame;

    always @(posedge Clk) begin
        if (Rst) begin
            n         = 0;
            exp_seg   = 7'h7F;
            exp_dig   = 6'h3F;
            exp_frame = 1'b0;
            for (int k = 0; k < 6; k++) snap_m[k] = 7'h7F;
        end else begin
            m_c       = n % DIV;
            m_idx     = (n / DIV) % 6;
            m_bp      = (n / BLINK_DIV) % 2;
            exp_frame = (n == 0) || (n % FRAME == FRAME - 1);
            if (m_c < BLANK_CYC) begin
                exp_seg = 7'h7F;
                exp_dig = 6'h3F;
            end else begin
                exp_dig = 6'h3F & ~(6'd1 << m_idx);
                exp_seg = (m_bp == 1 && blink[m_idx]) ? 7'h7F : snap_m[m_idx];
            end
            if (exp_frame) begin
                for (int k = 0; k < 6; k++) snap_m[k] = seg_in[k];
            end
            n++;
        end
    end

    always @(negedge Clk) begin
        if (checking) begin
            check("seg", o_seg, exp_seg);
            check("dig", o_dig, exp_dig);
            check("frame", o_frame, exp_frame);
            check("onehot", ($countones(~o_dig) <= 1), 1);
        end
    end

    task automatic wait_dig(input logic [5:0] d, input string tag);
        int k = 0;
        while (o_dig !== d && k < 200) begin
            @(negedge Clk);
            k++;
        end
        check(tag, o_dig, d);
    endtask

    task automatic wait_frame(input string tag);
        int k = 0;
        while (o_frame !== 1'b1 && k < 200) begin
            @(negedge Clk);
            k++;
        end
        check(tag, o_frame, 1'b1);
    endtask

    int cnt_on;
    int cnt_off;
    int cnt_bad;

    initial begin
        seg_in[0] = 7'h40; seg_in[1] = 7'h79; seg_in[2] = 7'h24;
        seg_in[3] = 7'h30; seg_in[4] = 7'h19; seg_in[5] = 7'h12;

        // Reset held for 3 clocks
        @(negedge Clk);
        checking = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        check("rst_seg", o_seg, 7'h7F);
        check("rst_dig", o_dig, 6'h3F);
        check("rst_frame", o_frame, 1'b0);
        Rst = 1'b0;
        begin
            int k = 0;
            @(negedge Clk);
            while (o_frame !== 1'b1 && k < 1) begin
                @(negedge Clk);
                k++;
            end
            check("frame_after_rst", o_frame, 1'b1);
        end

        // Scan order over two frames
        repeat (120) @(negedge Clk);

        // No tearing: change digit 3 while digit 1 is on
        wait_dig(6'h3F, "tear_wait_blank");
        wait_dig(6'b111101, "tear_wait_d1");
        seg_in[3] = 7'h00;
        wait_dig(6'b110111, "tear_wait_d3");
        check("tear_old_d3", o_seg, 7'h30);
        wait_frame("tear_frame");
        wait_dig(6'b110111, "tear_wait_d3_next");
        check("tear_new_d3", o_seg, 7'h00);

        // Blink digit 2
        blink = 6'b000100;
        cnt_on = 0; cnt_off = 0; cnt_bad = 0;
        repeat (600) begin
            @(negedge Clk);
            if (o_dig == 6'b111011) begin
                if (o_seg == 7'h24) cnt_on++;
                else if (o_seg == 7'h7F) cnt_off++;
                else cnt_bad++;
            end
        end
        check("blink_on_seen", (cnt_on > 0), 1);
        check("blink_off_seen", (cnt_off > 0), 1);
        check("blink_bad", cnt_bad, 0);

        // Randomized patterns and blink masks
        for (int r = 0; r < 8; r++) begin
            repeat ($urandom_range(20, 200)) @(negedge Clk);
            seg_in[$urandom_range(0, 5)] = 7'($urandom);
            if ($urandom_range(0, 1) == 1) seg_in[$urandom_range(0, 5)] = 7'($urandom);
            blink = 6'($urandom);
        end
        repeat (200) @(negedge Clk);

        // Mid-slot reset at c=5 of digit 4
        wait_dig(6'h3F, "mid_wait_blank");
        wait_dig(6'b101111, "mid_wait_d4");
        @(negedge Clk);
        @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        check("mid_rst_dig", o_dig, 6'h3F);
        check("mid_rst_seg", o_seg, 7'h7F);
        Rst = 1'b0;
        begin
            int k = 0;
            while (o_dig === 6'h3F && k < 20) begin
                @(negedge Clk);
                k++;
            end
            check("restart_d0", o_dig, 6'b111110);
        end
        repeat (100) @(negedge Clk);

        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
